// File: rtl/rr_budget_pkg.sv
// -----------------------------------------------------------------------------
// rr_budget_pkg
// Shared types and width helpers for the round-robin budget arbiter.
//   state_t : arbiter FSM state (IDLE, GRANT)
//   cw()    : counter/index width for a value range, never below one bit
// -----------------------------------------------------------------------------
package rr_budget_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Width needed to index n distinct values; a single value still gets one bit
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker: selects the first set bit of
// eligible at or after position ptr, wrapping modulo N.
// Ports:
//   eligible  in  N   candidate requesters
//   ptr       in  PW  highest-priority position
//   onehot    out N   one-hot winner (all zero when nothing eligible)
//   idx       out PW  winner index (0 when nothing eligible)
//   any       out 1   at least one candidate
// -----------------------------------------------------------------------------
module rr_pick
    import rr_budget_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] w_pos;
    logic [PW-1:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest eligible position wins
    always_comb begin
        w_pos = '0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = PW'((int'(ptr) + k) % N);
            w_idx = eligible[w_pos] ? w_pos : w_idx;
        end
    end

    assign any    = |eligible;
    assign idx    = w_idx;
    assign onehot = any ? (N'(1'b1) << w_idx) : '0;

endmodule

// File: rtl/rr_budget_arbiter.sv
// -----------------------------------------------------------------------------
// rr_budget_arbiter
// Shares one responder among N requesters: round-robin grant, per-requester
// grant budget reloaded every WINDOW cycles, sticky error on starvation or on
// a done pulse with no transaction outstanding.
// Ports:
//   clk      in   1  clock, posedge
//   rst      in   1  synchronous active-high reset
//   req      in   N  level requests, may drop at any time
//   done     in   1  responder finished current transaction (pulse)
//   grant    out  N  registered one-hot grant, zero when idle
//   busy     out  1  registered, high while in GRANT
//   error    out  1  sticky error flag, cleared only by rst
//   _rt_get  out  1  combinational OR of req
// -----------------------------------------------------------------------------
module rr_budget_arbiter
    import rr_budget_pkg::*;
#(
    parameter int N        = 2,
    parameter int BUDGET   = 3,
    parameter int WINDOW   = 8,
    parameter int MAX_WAIT = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         error,
    output logic         _rt_get
);

    localparam int PW = cw(N);
    localparam int BW = cw(BUDGET + 1);
    localparam int WW = cw(MAX_WAIT + 1);
    localparam int CW = cw(WINDOW);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  w_grant_nxt;
    logic          r_busy;
    logic          r_error;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic [PW-1:0] r_winner;
    logic [PW-1:0] w_winner_nxt;
    logic          w_take;
    logic [CW-1:0] r_win_cnt;
    logic          w_win_last;
    logic [BW-1:0] r_budget [N];
    logic [WW-1:0] r_wait   [N];
    logic [N-1:0]  w_eligible;
    logic [N-1:0]  w_onehot;
    logic [PW-1:0] w_idx;
    logic          w_any;
    logic          w_starve;

    // A requester is eligible only while it still has budget in this window
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < N; i++) begin
            w_eligible[i] = req[i] && (r_budget[i] != '0);
        end
    end

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .eligible (w_eligible),
        .ptr      (r_ptr),
        .onehot   (w_onehot),
        .idx      (w_idx),
        .any      (w_any)
    );

    // FSM next state, grant vector, priority pointer and budget-consume strobe
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_ptr_nxt    = r_ptr;
        w_winner_nxt = r_winner;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt  = GRANT;
                    w_grant_nxt  = w_onehot;
                    w_winner_nxt = w_idx;
                end else begin
                    w_grant_nxt  = '0;
                end
            end
            GRANT: begin
                // Grant is frozen until done, whatever req does meanwhile
                if (done) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = (r_winner == PW'(N - 1)) ? '0 : r_winner + PW'(1);
                    w_take      = 1'b1;
                end else begin
                    w_state_nxt = GRANT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // FSM state, grant, busy, pointer and current winner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_ptr    <= '0;
            r_winner <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_busy   <= (w_state_nxt == GRANT);
            r_ptr    <= w_ptr_nxt;
            r_winner <= w_winner_nxt;
        end
    end

    assign w_win_last = (r_win_cnt == CW'(WINDOW - 1));

    // Free-running window counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt <= '0;
        end else if (w_win_last) begin
            r_win_cnt <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + CW'(1);
        end
    end

    // Budgets: window reload takes priority over a same-cycle decrement
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                r_budget[i] <= BW'(BUDGET);
            end else if (w_win_last) begin
                r_budget[i] <= BW'(BUDGET);
            end else if (w_take && (r_winner == PW'(i)) && (r_budget[i] != '0)) begin
                r_budget[i] <= r_budget[i] - BW'(1);
            end else begin
                r_budget[i] <= r_budget[i];
            end
        end
    end

    // Wait counters: count pending-but-ungranted cycles, saturating at MAX_WAIT
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                r_wait[i] <= '0;
            end else if (!req[i] || r_grant[i]) begin
                r_wait[i] <= '0;
            end else if (r_wait[i] != WW'(MAX_WAIT)) begin
                r_wait[i] <= r_wait[i] + WW'(1);
            end else begin
                r_wait[i] <= r_wait[i];
            end
        end
    end

    // Any requester that has waited the full limit is starving
    always_comb begin
        w_starve = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_starve = w_starve | (r_wait[i] == WW'(MAX_WAIT));
        end
    end

    // Sticky error: starvation, or done with no transaction outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (((r_state == IDLE) && done) || w_starve) begin
            r_error <= 1'b1;
        end else begin
            r_error <= r_error;
        end
    end

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign error   = r_error;
    assign _rt_get = |req;

endmodule

// File: tb/tb_rr_budget_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_budget_arbiter
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences for budget exhaustion, reload-vs-decrement and starvation, then
// random traffic compared against an integer behavioural model.
// -----------------------------------------------------------------------------
module tb_rr_budget_arbiter;

    localparam int N        = 2;
    localparam int BUDGET   = 3;
    localparam int WINDOW   = 8;
    localparam int MAX_WAIT = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic         busy;
    logic         error;
    logic         rt_get;

    int total = 0;
    int bad   = 0;

    // Behavioural model state (plain integers)
    int m_busy, m_winner, m_ptr, m_win, m_err;
    int m_bud  [N];
    int m_wait [N];

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       done;
        logic [1:0] g;
        logic       b;
        logic       e;
    } vec_t;

    vec_t vecs [16];

    rr_budget_arbiter #(
        .N(N), .BUDGET(BUDGET), .WINDOW(WINDOW), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .busy    (busy),
        .error   (error),
        ._rt_get (rt_get)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One clock of the specification's rules, applied to the sampled inputs
    task automatic model_update();
        int dec;
        dec = -1;
        if (rst) begin
            m_busy = 0; m_winner = 0; m_ptr = 0; m_win = 0; m_err = 0;
            for (int i = 0; i < N; i++) begin
                m_bud[i]  = BUDGET;
                m_wait[i] = 0;
            end
            return;
        end
        if (m_busy == 0 && done) m_err = 1;
        for (int i = 0; i < N; i++) if (m_wait[i] >= MAX_WAIT) m_err = 1;
        for (int i = 0; i < N; i++) begin
            if (!req[i] || (m_busy != 0 && m_winner == i)) m_wait[i] = 0;
            else if (m_wait[i] < MAX_WAIT) m_wait[i] = m_wait[i] + 1;
        end
        if (m_busy == 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_busy == 0 && req[j] && m_bud[j] > 0) begin
                    m_busy   = 1;
                    m_winner = j;
                end
            end
        end else if (done) begin
            m_busy = 0;
            m_ptr  = (m_winner + 1) % N;
            dec    = m_winner;
        end
        if (m_win == WINDOW - 1) begin
            for (int i = 0; i < N; i++) m_bud[i] = BUDGET;
        end else if (dec >= 0 && m_bud[dec] > 0) begin
            m_bud[dec] = m_bud[dec] - 1;
        end
        m_win = (m_win + 1) % WINDOW;
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_busy != 0) g[m_winner] = 1'b1;
        return g;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] q, input logic d);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk_model();
        chk("rand_grant", grant, model_grant());
        chk("rand_busy", busy, m_busy[0]);
        chk("rand_error", error, m_err[0]);
        chk("rand_rt_get", rt_get, |req);
    endtask

    logic         t_d [15];
    logic [1:0]   t_q [15];
    logic [1:0]   t_g [15];
    logic         rr_s;
    logic [1:0]   qq_s;
    logic         dd_s;

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;

        // T1 reset, T2 alternating grants with reload on done at win 7, T6 protocol
        vecs[0]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
        for (int v = 0; v < 16; v++) begin
            step(vecs[v].rst, vecs[v].req, vecs[v].done);
            chk($sformatf("vec%0d_grant", v), grant, vecs[v].g);
            chk($sformatf("vec%0d_busy", v), busy, vecs[v].b);
            chk($sformatf("vec%0d_error", v), error, vecs[v].e);
        end

        // T3 budget exhaustion: three grants, silence until reload, fourth grant
        t_d[0:8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        t_g[0:8] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        step(1'b1, 2'b00, 1'b0);
        for (int s = 0; s < 9; s++) begin
            step(1'b0, 2'b01, t_d[s]);
            chk($sformatf("t3_grant%0d", s), grant, t_g[s]);
        end
        chk("t3_error", error, 1'b0);

        // T4 done at win 7: reload wins, so three more grants fit the next window
        t_q = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        t_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t_g = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
        step(1'b1, 2'b00, 1'b0);
        for (int s = 0; s < 15; s++) begin
            step(1'b0, t_q[s], t_d[s]);
            chk($sformatf("t4_grant%0d", s), grant, t_g[s]);
        end

        // T5 starvation of req1 behind a held grant to req0
        step(1'b1, 2'b00, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        chk("t5_grant0", grant, 2'b01);
        for (int s = 0; s < MAX_WAIT; s++) begin
            step(1'b0, 2'b10, 1'b0);
            chk($sformatf("t5_noerr%0d", s), error, 1'b0);
        end
        step(1'b0, 2'b10, 1'b0);
        chk("t5_err", error, 1'b1);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 2'b00, 1'b0);
            chk($sformatf("t5_sticky%0d", s), error, 1'b1);
            chk($sformatf("t5_hold%0d", s), grant, 2'b01);
        end

        // Random traffic against the model
        step(1'b1, 2'b00, 1'b0);
        chk_model();
        for (int c = 0; c < 3000; c++) begin
            rr_s = ($urandom_range(0, 59) == 0);
            qq_s = req;
            if ($urandom_range(0, 3) == 0) qq_s = 2'($urandom_range(0, 3));
            if (m_busy != 0) dd_s = ($urandom_range(0, 2) == 0);
            else             dd_s = ($urandom_range(0, 79) == 0);
            step(rr_s, qq_s, dd_s);
            chk_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
